// File: rtl/conv_engine_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | conv_engine_if : scheduler handshake plus shared DRAM port bundle       |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
interface conv_engine_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18
);
  logic                  enable;
  logic                  done;
  logic                  dram_valid;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic [ADDR_WIDTH-1:0] addr_in;
  logic [ADDR_WIDTH-1:0] addr_out;
  logic                  dram_en_rd;
  logic                  dram_en_wr;

  // master = the engine, slave = scheduler/DRAM side
  modport master (
    input  enable, dram_valid, data_in,
    output done, data_out, addr_in, addr_out, dram_en_rd, dram_en_wr
  );

  modport slave (
    output enable, dram_valid, data_in,
    input  done, data_out, addr_in, addr_out, dram_en_rd, dram_en_wr
  );
endinterface
`default_nettype wire

// File: rtl/conv_engine.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | conv_engine : single-MAC valid-padding conv layer (stride 1/2, bias)   |
// | Optional: CONV_RELU_EN clamps negative outputs to 0.   Rev 1.0         |
// +-----------------------------------------------------------------------+
module conv_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16,
  parameter int ADDR_WIDTH = 18,
  parameter int KNL_SIZE   = 5,
  parameter int MAX_CHNL   = 32,
  parameter int HDR_ADDR   = 0,
  parameter int BIAS_BASE  = 16,
  parameter int WGT_BASE   = 64,
  parameter int IFMAP_BASE = 65536,
  parameter int OFMAP_BASE = 131072
) (
  input wire logic      clk,
  input wire logic      arst,
  conv_engine_if.master bus
);

  localparam int c_acc_w  = DATA_WIDTH + 8;
  localparam int c_prod_w = 2 * DATA_WIDTH;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LD_HDR  = 3'd1;
  localparam logic [2:0] S_LD_BIAS = 3'd2;
  localparam logic [2:0] S_LD_WGT  = 3'd3;
  localparam logic [2:0] S_LD_PIX  = 3'd4;
  localparam logic [2:0] S_MAC     = 3'd5;
  localparam logic [2:0] S_WR      = 3'd6;
  localparam logic [2:0] S_DONE    = 3'd7;

  localparam logic [7:0]            c_k8      = 8'(KNL_SIZE);
  localparam logic [2:0]            c_k_last  = 3'(KNL_SIZE - 1);
  localparam logic [6:0]            c_max_ch  = 7'(MAX_CHNL);
  localparam logic [ADDR_WIDTH-1:0] c_k_a     = ADDR_WIDTH'(KNL_SIZE);
  localparam logic [ADDR_WIDTH-1:0] c_hdr_a   = ADDR_WIDTH'(HDR_ADDR);
  localparam logic [ADDR_WIDTH-1:0] c_bias_a  = ADDR_WIDTH'(BIAS_BASE);
  localparam logic [ADDR_WIDTH-1:0] c_wgt_a   = ADDR_WIDTH'(WGT_BASE);
  localparam logic [ADDR_WIDTH-1:0] c_ifmap_a = ADDR_WIDTH'(IFMAP_BASE);
  localparam logic [ADDR_WIDTH-1:0] c_ofmap_a = ADDR_WIDTH'(OFMAP_BASE);
  localparam logic [c_acc_w-1:0]    c_acc_max = {1'b0, {(c_acc_w-1){1'b1}}};
  localparam logic [c_acc_w-1:0]    c_acc_min = {1'b1, {(c_acc_w-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] c_out_max = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] c_out_min = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [2:0]            r_state, w_state_nxt;
  logic                  r_rd_en;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [5:0]            r_oc, r_ic, r_co, r_ci;
  logic [7:0]            r_w, r_h, r_oh, r_ow, r_oy, r_ox;
  logic                  r_s;
  logic [2:0]            r_ky, r_kx;
  logic [c_acc_w-1:0]    r_acc;
  logic [DATA_WIDTH-1:0] r_wgt, r_pix;

  // ---------------- header decode ----------------
  logic [5:0] w_hdr_oc, w_hdr_ic;
  logic [7:0] w_hdr_w, w_hdr_h, w_hdr_oh, w_hdr_ow;
  logic       w_hdr_s, w_hdr_bad;

  assign w_hdr_oc  = bus.data_in[5:0];
  assign w_hdr_ic  = bus.data_in[11:6];
  assign w_hdr_w   = bus.data_in[19:12];
  assign w_hdr_h   = bus.data_in[27:20];
  assign w_hdr_s   = bus.data_in[28];
  assign w_hdr_bad = (w_hdr_oc == 6'd0) || (w_hdr_ic == 6'd0) ||
                     ({1'b0, w_hdr_oc} > c_max_ch) || ({1'b0, w_hdr_ic} > c_max_ch) ||
                     (w_hdr_w < c_k8) || (w_hdr_h < c_k8);
  assign w_hdr_oh  = (w_hdr_s ? ((w_hdr_h - c_k8) >> 1) : (w_hdr_h - c_k8)) + 8'd1;
  assign w_hdr_ow  = (w_hdr_s ? ((w_hdr_w - c_k8) >> 1) : (w_hdr_w - c_k8)) + 8'd1;

  // ---------------- loop bookkeeping ----------------
  logic w_rd_ack, w_is_ld;
  logic w_last_kx, w_last_ky, w_last_ci, w_last_tap;
  logic w_last_ox, w_last_oy, w_last_co, w_last_px;

  assign w_rd_ack   = r_rd_en & bus.dram_valid;
  assign w_is_ld    = (r_state == S_LD_HDR) || (r_state == S_LD_BIAS) ||
                      (r_state == S_LD_WGT) || (r_state == S_LD_PIX);
  assign w_last_kx  = (r_kx == c_k_last);
  assign w_last_ky  = (r_ky == c_k_last);
  assign w_last_ci  = (r_ci == r_ic - 6'd1);
  assign w_last_tap = w_last_kx && w_last_ky && w_last_ci;
  assign w_last_ox  = (r_ox == r_ow - 8'd1);
  assign w_last_oy  = (r_oy == r_oh - 8'd1);
  assign w_last_co  = (r_co == r_oc - 6'd1);
  assign w_last_px  = w_last_ox && w_last_oy && w_last_co;

  // ---------------- address generation (wraps at ADDR_WIDTH) ----------------
  logic [ADDR_WIDTH-1:0] w_co_a, w_ci_a, w_ic_a, w_ky_a, w_kx_a;
  logic [ADDR_WIDTH-1:0] w_oy_a, w_ox_a, w_w_a, w_h_a, w_oh_a, w_ow_a;
  logic [ADDR_WIDTH-1:0] w_wgt_addr, w_pix_addr, w_out_addr, w_rd_addr;

  assign w_co_a = ADDR_WIDTH'(r_co);
  assign w_ci_a = ADDR_WIDTH'(r_ci);
  assign w_ic_a = ADDR_WIDTH'(r_ic);
  assign w_ky_a = ADDR_WIDTH'(r_ky);
  assign w_kx_a = ADDR_WIDTH'(r_kx);
  assign w_oy_a = ADDR_WIDTH'(r_oy);
  assign w_ox_a = ADDR_WIDTH'(r_ox);
  assign w_w_a  = ADDR_WIDTH'(r_w);
  assign w_h_a  = ADDR_WIDTH'(r_h);
  assign w_oh_a = ADDR_WIDTH'(r_oh);
  assign w_ow_a = ADDR_WIDTH'(r_ow);

  assign w_wgt_addr = c_wgt_a + ((w_co_a * w_ic_a + w_ci_a) * c_k_a + w_ky_a) * c_k_a + w_kx_a;
  assign w_pix_addr = c_ifmap_a + (w_ci_a * w_h_a + (w_oy_a << r_s) + w_ky_a) * w_w_a
                      + (w_ox_a << r_s) + w_kx_a;
  assign w_out_addr = c_ofmap_a + (w_co_a * w_oh_a + w_oy_a) * w_ow_a + w_ox_a;

  always_comb begin
    w_rd_addr = c_hdr_a;
    case (r_state)
      S_LD_BIAS: w_rd_addr = c_bias_a + w_co_a;
      S_LD_WGT:  w_rd_addr = w_wgt_addr;
      S_LD_PIX:  w_rd_addr = w_pix_addr;
      default:   w_rd_addr = c_hdr_a;
    endcase
  end

  // ---------------- MAC: the accumulator clamps instead of wrapping ----------------
  logic signed [c_prod_w-1:0] w_prod, w_term;
  logic [c_acc_w-1:0]         w_term_sat, w_acc_nxt;
  logic [c_acc_w:0]           w_sum;
  logic                       w_term_fits;

  assign w_prod      = $signed(r_wgt) * $signed(r_pix);
  assign w_term      = w_prod >>> FRAC_BITS;
  assign w_term_fits = (&w_term[c_prod_w-1:c_acc_w-1]) || ~(|w_term[c_prod_w-1:c_acc_w-1]);
  assign w_term_sat  = w_term_fits ? w_term[c_acc_w-1:0] :
                       (w_term[c_prod_w-1] ? c_acc_min : c_acc_max);
  assign w_sum       = {r_acc[c_acc_w-1], r_acc} + {w_term_sat[c_acc_w-1], w_term_sat};
  assign w_acc_nxt   = (w_sum[c_acc_w] == w_sum[c_acc_w-1]) ? w_sum[c_acc_w-1:0] :
                       (w_sum[c_acc_w] ? c_acc_min : c_acc_max);

  // ---------------- output saturation ----------------
  logic                  w_acc_fits;
  logic [DATA_WIDTH-1:0] w_sat, w_wr_data;

  assign w_acc_fits = (&r_acc[c_acc_w-1:DATA_WIDTH-1]) || ~(|r_acc[c_acc_w-1:DATA_WIDTH-1]);
  assign w_sat      = w_acc_fits ? r_acc[DATA_WIDTH-1:0] :
                      (r_acc[c_acc_w-1] ? c_out_min : c_out_max);
`ifdef CONV_RELU_EN
  assign w_wr_data  = w_sat[DATA_WIDTH-1] ? '0 : w_sat;
`else
  assign w_wr_data  = w_sat;
`endif

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge arst) begin
    if (arst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (bus.enable) w_state_nxt = S_LD_HDR;
      S_LD_HDR:  if (w_rd_ack)   w_state_nxt = w_hdr_bad ? S_DONE : S_LD_BIAS;
      S_LD_BIAS: if (w_rd_ack)   w_state_nxt = S_LD_WGT;
      S_LD_WGT:  if (w_rd_ack)   w_state_nxt = S_LD_PIX;
      S_LD_PIX:  if (w_rd_ack)   w_state_nxt = S_MAC;
      S_MAC:     w_state_nxt = w_last_tap ? S_WR : S_LD_WGT;
      S_WR:      w_state_nxt = w_last_px ? S_DONE : S_LD_BIAS;
      S_DONE:    if (!bus.enable) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.dram_en_wr = 1'b0;
    bus.addr_out   = '0;
    bus.data_out   = '0;
    bus.done       = (r_state == S_DONE);
    if (r_state == S_WR) begin
      bus.dram_en_wr = 1'b1;
      bus.addr_out   = w_out_addr;
      bus.data_out   = w_wr_data;
    end
  end

  assign bus.dram_en_rd = r_rd_en;
  assign bus.addr_in    = r_rd_addr;

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_oc      <= '0;
      r_ic      <= '0;
      r_w       <= '0;
      r_h       <= '0;
      r_s       <= 1'b0;
      r_oh      <= '0;
      r_ow      <= '0;
      r_co      <= '0;
      r_ci      <= '0;
      r_oy      <= '0;
      r_ox      <= '0;
      r_ky      <= '0;
      r_kx      <= '0;
      r_acc     <= '0;
      r_wgt     <= '0;
      r_pix     <= '0;
    end else begin
      // Each load state raises its request on its first cycle and holds it until data arrives.
      if (w_rd_ack) begin
        r_rd_en <= 1'b0;
      end else if (w_is_ld && !r_rd_en) begin
        r_rd_en   <= 1'b1;
        r_rd_addr <= w_rd_addr;
      end

      case (r_state)
        S_LD_HDR: if (w_rd_ack) begin
          r_oc <= w_hdr_oc;
          r_ic <= w_hdr_ic;
          r_w  <= w_hdr_w;
          r_h  <= w_hdr_h;
          r_s  <= w_hdr_s;
          r_oh <= w_hdr_oh;
          r_ow <= w_hdr_ow;
          r_co <= '0;
          r_ci <= '0;
          r_oy <= '0;
          r_ox <= '0;
          r_ky <= '0;
          r_kx <= '0;
        end
        S_LD_BIAS: if (w_rd_ack) begin
          r_acc <= {{(c_acc_w-DATA_WIDTH){bus.data_in[DATA_WIDTH-1]}}, bus.data_in};
        end
        S_LD_WGT: if (w_rd_ack) r_wgt <= bus.data_in;
        S_LD_PIX: if (w_rd_ack) r_pix <= bus.data_in;
        S_MAC: begin
          r_acc <= w_acc_nxt;
          if (w_last_kx) begin
            r_kx <= '0;
            if (w_last_ky) begin
              r_ky <= '0;
              r_ci <= w_last_ci ? 6'd0 : r_ci + 6'd1;
            end else begin
              r_ky <= r_ky + 3'd1;
            end
          end else begin
            r_kx <= r_kx + 3'd1;
          end
        end
        S_WR: begin
          if (w_last_ox) begin
            r_ox <= '0;
            if (w_last_oy) begin
              r_oy <= '0;
              r_co <= w_last_co ? 6'd0 : r_co + 6'd1;
            end else begin
              r_oy <= r_oy + 8'd1;
            end
          end else begin
            r_ox <= r_ox + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/conv_engine.md
Name: conv_engine

Overview:
- Parametrised successor to the single-PE conv layer block: one signed fixed-point MAC plus sequencing FSM.
- Computes a full valid-padding 2-D convolution layer: multi-channel input, multi-kernel output, per-channel bias, kernel size K, stride 1 or 2.
- Reads header, weights, bias and ifmap from DRAM; writes ofmap back to DRAM.
- Sits between the layer scheduler (enable/done) and the shared DRAM port.

Parameters:
- DATA_WIDTH, 32: word width, signed fixed point.
- FRAC_BITS, 16: fractional bits of every operand and result.
- ADDR_WIDTH, 18: DRAM word address width.
- KNL_SIZE, 5: kernel edge K, 1..7.
- MAX_CHNL, 32: maximum input and output channel count.
- HDR_ADDR, 0: header word address.
- BIAS_BASE, 16: bias base; one word per output channel.
- WGT_BASE, 64: weight base.
- IFMAP_BASE, 65536: ifmap base.
- OFMAP_BASE, 131072: ofmap base.

Ports:
- clk  in  1  clock; all logic on rising edge.
- arst  in  1  asynchronous active-high reset.
- enable  in  1  start request, level; sampled only in IDLE.
- dram_valid  in  1  read data on data_in valid this cycle.
- data_in  in  DATA_WIDTH  DRAM read data.
- data_out  out  DATA_WIDTH  ofmap write data.
- addr_in  out  ADDR_WIDTH  read address.
- addr_out  out  ADDR_WIDTH  write address.
- dram_en_rd  out  1  read request.
- dram_en_wr  out  1  write strobe.
- done  out  1  layer complete.

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters and accumulator 0. arst mid-operation aborts immediately with no further DRAM access.
- Read handshake:
  - dram_en_rd and addr_in are registered and held stable until the cycle dram_valid=1.
  - data_in is captured that cycle and dram_en_rd drops next cycle.
  - dram_valid while dram_en_rd=0 is ignored.
- Write handshake: dram_en_wr is a single-cycle pulse with addr_out/data_out valid that same cycle; DRAM always accepts.
- FSM:
  - IDLE -> LD_HDR when enable=1.
  - LD_HDR: read HDR_ADDR. Fields: [5:0] OC, [11:6] IC, [19:12] W, [27:20] H, [28] S (0 = stride 1, 1 = stride 2).
  - Go to DONE directly if OC=0, IC=0, OC>MAX_CHNL, IC>MAX_CHNL, W<K or H<K; otherwise go to LD_BIAS.
  - OH=(H-K)/S+1, OW=(W-K)/S+1 (integer floor).
  - LD_BIAS: read BIAS_BASE+co; acc<=sign-extended bias -> LD_WGT.
  - LD_WGT: read WGT_BASE+((co*IC+ci)*K+ky)*K+kx -> LD_PIX.
  - LD_PIX: read IFMAP_BASE+(ci*H+oy*S+ky)*W+ox*S+kx -> MAC.
  - MAC (1 cycle): acc += (w*x)>>>FRAC_BITS. Full 2*DATA_WIDTH signed product, arithmetic shift, accumulator DATA_WIDTH+8 bits. Advance kx, then ky, then ci.
  - After the last (ci,ky,kx) -> WR, else -> LD_WGT.
  - WR: data_out = acc saturated to DATA_WIDTH signed range (0x7FFFFFFF / 0x80000000). addr_out=OFMAP_BASE+(co*OH+oy)*OW+ox.
  - After WR, advance ox, then oy, then co. Next pixel -> LD_BIAS; after the last pixel of the last channel -> DONE.
  - DONE: done=1; hold until enable=0, then IDLE next cycle with done=0.
- enable changes outside IDLE/DONE are ignored.
- Address arithmetic wraps modulo 2^ADDR_WIDTH; no range checking.
- Each output uses 1 bias read, 2*IC*K*K reads, IC*K*K MAC cycles and 1 write.

Optional Feature:
- CONV_RELU_EN defined: in WR, saturated negative results are written as 0; non-negative values are unchanged.
- Not defined: the signed saturated value is written.

Test Plan:
- Minimum layer: header OC=1, IC=1, W=H=5, S=0; all weights 0x00010000, all pixels 0x00010000, bias 0x00008000. Expect exactly one write: addr_out=131072, data_out=0x00198000 (25.5). Then done=1.
- Stride 2 with multiple channels: OC=2, IC=3, W=H=9, S=1. Expect OH=OW=3 and 18 writes at 131072..131089 in co/oy/ox order. Values match the golden model with random Q16.16 data.
- Saturation: weights and pixels 0x7FFF0000, bias 0x7FFFFFFF. Expect data_out=0x7FFFFFFF. Negating the weights gives 0x80000000, or 0 with CONV_RELU_EN.
- Degenerate headers: W=4 (less than K), or OC=0. Expect no writes and done=1 within 3 cycles of the header dram_valid.
- DRAM stalls and stray valids: random 0-10 cycle dram_valid latency, plus spurious dram_valid while dram_en_rd=0. Expect addr_in stable while dram_en_rd=1 and results identical to the zero-stall run.
- Reset mid-layer: assert arst during the 3rd MAC. Expect all outputs 0 immediately and no write afterwards. Then re-run with enable and expect a complete correct layer.
